// File: rtl/time_pkg.sv
// Shared encodings and limits for the BCD time-of-day counter.
package time_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_SET_H = 2'd1,
    MODE_SET_M = 2'd2
  } mode_e;

  localparam logic [5:0] SEC_MAX     = 6'd59;
  localparam logic [5:0] MIN_MAX     = 6'd59;
  localparam logic [3:0] DIGIT_MAX   = 4'd9;
  localparam logic [3:0] TENS_MAX_MS = 4'd5;

  // Binary 0..63 to two BCD digits; used on constant limits only.
  function automatic logic [7:0] bin_to_bcd(input logic [5:0] b);
    logic [5:0] t;
    logic [5:0] u;
    t = b / 6'd10;
    u = b % 6'd10;
    return {t[3:0], u[3:0]};
  endfunction

endpackage

// File: rtl/time_counter_bcd_if.sv
// Signal bundle between the 1 Hz source / buttons and the time counter.
interface time_counter_bcd_if;
  // No valid/ready here: clk_1 is a level, btn_* are single-cycle pulses sampled
  // on clk, and every output is a registered level or single-cycle pulse.
  logic       clk_1;
  logic       btn_mode;
  logic       btn_inc;
  logic [7:0] hh_bcd;
  logic [7:0] mm_bcd;
  logic [7:0] ss_bcd;
  logic [1:0] mode;
  logic       tick;
  logic       day_wrap;

  modport master (
    output clk_1, btn_mode, btn_inc,
    input  hh_bcd, mm_bcd, ss_bcd, mode, tick, day_wrap
  );

  modport slave (
    input  clk_1, btn_mode, btn_inc,
    output hh_bcd, mm_bcd, ss_bcd, mode, tick, day_wrap
  );
endinterface

// File: rtl/bcd2_counter.sv
// Two-digit BCD counter wrapping to 00 after a binary-programmed maximum.
module bcd2_counter
  import time_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       clr,
  input  logic [5:0] max_bin,
  output logic [7:0] value,
  output logic       carry
);

  logic [7:0] max_bcd;

  assign max_bcd = bin_to_bcd(max_bin);
  assign carry   = inc & (value == max_bcd);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= 8'h00;
    end else if (carry) begin
      value <= 8'h00;
    end else if (inc) begin
      if (value[3:0] == DIGIT_MAX)
        value <= {value[7:4] + 4'd1, 4'd0};
      else
        value[3:0] <= value[3:0] + 4'd1;
    end
  end

endmodule

// File: rtl/time_counter_bcd.sv
// HH:MM:SS BCD time-of-day counter driven by rising edges of a 1 Hz wave,
// with a RUN / SET_H / SET_M mode FSM for adjusting hours and minutes.
module time_counter_bcd
  import time_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  time_counter_bcd_if.slave    bus
);

  localparam logic [5:0] HH_MAX = 6'(HOUR_MAX);

  mode_e      mode_q, mode_d;
  logic       clk_1_d;
  logic       rise;
  logic       tick_q, day_wrap_q;
  logic       run;
  logic       ss_inc, mm_inc, hh_inc, ss_clr;
  logic       ss_carry, mm_carry, hh_carry;
  logic [7:0] ss_val, mm_val, hh_val;

  assign rise = bus.clk_1 & ~clk_1_d;
  assign run  = (mode_q == MODE_RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= MODE_RUN;
      clk_1_d    <= 1'b1;
      tick_q     <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      clk_1_d    <= bus.clk_1;
      tick_q     <= rise;
      day_wrap_q <= run & hh_carry;
    end
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_RUN:   if (bus.btn_mode) mode_d = MODE_SET_H;
      MODE_SET_H: if (bus.btn_mode) mode_d = MODE_SET_M;
      MODE_SET_M: if (bus.btn_mode) mode_d = MODE_RUN;
      default:    mode_d = MODE_RUN;
    endcase
  end

  // In set modes the counters ignore seconds; a mode press drops a same-cycle inc.
  always_comb begin
    ss_inc = run & rise;
    ss_clr = (mode_q == MODE_SET_M) & bus.btn_mode;
    mm_inc = 1'b0;
    hh_inc = 1'b0;
    if (run) begin
      mm_inc = ss_carry;
      hh_inc = mm_carry;
    end else begin
      mm_inc = (mode_q == MODE_SET_M) & bus.btn_inc & ~bus.btn_mode;
      hh_inc = (mode_q == MODE_SET_H) & bus.btn_inc & ~bus.btn_mode;
    end
  end

  bcd2_counter u_ss (
    .clk(clk), .rst(rst), .inc(ss_inc), .clr(ss_clr),
    .max_bin(SEC_MAX), .value(ss_val), .carry(ss_carry)
  );

  bcd2_counter u_mm (
    .clk(clk), .rst(rst), .inc(mm_inc), .clr(1'b0),
    .max_bin(MIN_MAX), .value(mm_val), .carry(mm_carry)
  );

  bcd2_counter u_hh (
    .clk(clk), .rst(rst), .inc(hh_inc), .clr(1'b0),
    .max_bin(HH_MAX), .value(hh_val), .carry(hh_carry)
  );

  assign bus.hh_bcd   = hh_val;
  assign bus.mm_bcd   = mm_val;
  assign bus.ss_bcd   = ss_val;
  assign bus.mode     = mode_q;
  assign bus.tick     = tick_q;
  assign bus.day_wrap = day_wrap_q;

endmodule

// File: tb/tb_time_counter_bcd.sv
// Bench for time_counter_bcd: a seconds-of-day reference model compared against
// the DUT after every clock edge in directed and randomized scenarios.
module tb_time_counter_bcd;

  localparam int HOUR_MAX = 23;

  logic clk;
  logic rst;
  time_counter_bcd_if bus ();

  time_counter_bcd #(.HOUR_MAX(HOUR_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_h, m_m, m_s, m_mode;
  bit m_prev, m_tick, m_wrap;

  function automatic logic [7:0] to_bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [27:0] exp_vec();
    return {to_bcd(m_h), to_bcd(m_m), to_bcd(m_s), 2'(m_mode), m_tick, m_wrap};
  endfunction

  function automatic logic [27:0] dut_vec();
    return {bus.hh_bcd, bus.mm_bcd, bus.ss_bcd, bus.mode, bus.tick, bus.day_wrap};
  endfunction

  function automatic bit digits_ok();
    return (bus.hh_bcd[3:0] <= 4'd9) && (bus.hh_bcd[7:4] <= 4'd9) &&
           (bus.mm_bcd[3:0] <= 4'd9) && (bus.mm_bcd[7:4] <= 4'd5) &&
           (bus.ss_bcd[3:0] <= 4'd9) && (bus.ss_bcd[7:4] <= 4'd5);
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, settle.
  task automatic step(input logic c1, input logic bm, input logic bi, input logic r);
    int  secs;
    bit  rise;
    bus.clk_1    = c1;
    bus.btn_mode = bm;
    bus.btn_inc  = bi;
    rst          = r;
    @(posedge clk);
    if (r) begin
      m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
      m_tick = 0; m_wrap = 0; m_prev = 1;
    end else begin
      rise   = c1 && !m_prev;
      m_prev = c1;
      m_tick = rise;
      m_wrap = 0;
      case (m_mode)
        0: begin
          if (rise) begin
            secs = m_h * 3600 + m_m * 60 + m_s + 1;
            if (secs == (HOUR_MAX + 1) * 3600) begin
              secs   = 0;
              m_wrap = 1;
            end
            m_h = secs / 3600;
            m_m = (secs / 60) % 60;
            m_s = secs % 60;
          end
          if (bm) m_mode = 1;
        end
        1: begin
          if (bm) m_mode = 2;
          else if (bi) m_h = (m_h + 1) % (HOUR_MAX + 1);
        end
        default: begin
          if (bm) begin m_mode = 0; m_s = 0; end
          else if (bi) m_m = (m_m + 1) % 60;
        end
      endcase
    end
    #1;
  endtask

  task automatic rises(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (dut_vec() !== 28'h0) begin
      bad++; $display("FAIL reset_state got=%h want=%h", dut_vec(), 28'h0);
    end
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (dut_vec() !== 28'h0) begin
        bad++; $display("FAIL reset_high_no_tick cyc=%0d got=%h want=%h", i, dut_vec(), 28'h0);
      end
    end
  endtask

  task automatic test_tick();
    step(1'b0, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.tick !== 1'b0) begin
      bad++; $display("FAIL tick_low got=%b want=0", bus.tick);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.tick, bus.ss_bcd} !== {1'b1, 8'h01}) begin
      bad++; $display("FAIL first_tick got=%b/%h want=1/01", bus.tick, bus.ss_bcd);
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if (bus.tick !== 1'b0) begin
      bad++; $display("FAIL tick_one_cycle got=%b want=0", bus.tick);
    end
    for (int i = 0; i < 59; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL count_seconds i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
      total++;
      if (digits_ok() !== 1'b1) begin
        bad++; $display("FAIL bcd_digits i=%0d got=%h/%h/%h", i, bus.hh_bcd, bus.mm_bcd, bus.ss_bcd);
      end
    end
    total++;
    if ({bus.mm_bcd, bus.ss_bcd} !== 16'h0100) begin
      bad++; $display("FAIL minute_carry got=%h%h want=0100", bus.mm_bcd, bus.ss_bcd);
    end
  endtask

  task automatic test_set();
    rises(5);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.mode !== 2'd1) begin
      bad++; $display("FAIL enter_set_h got=%0d want=1", bus.mode);
    end
    for (int i = 0; i < 25; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus.hh_bcd !== 8'h01) begin
      bad++; $display("FAIL set_h_wrap got=%h want=01", bus.hh_bcd);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (bus.mode !== 2'd2) begin
      bad++; $display("FAIL enter_set_m got=%0d want=2", bus.mode);
    end
    for (int i = 0; i < 57; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if (bus.mm_bcd !== 8'h58) begin
      bad++; $display("FAIL set_m_58 got=%h want=58", bus.mm_bcd);
    end
    for (int i = 0; i < 61; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    total++;
    if ({bus.hh_bcd, bus.mm_bcd} !== 16'h0159) begin
      bad++; $display("FAIL set_m_wrap_no_carry got=%h%h want=0159", bus.hh_bcd, bus.mm_bcd);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({bus.mode, bus.ss_bcd} !== {2'd0, 8'h00}) begin
      bad++; $display("FAIL exit_clears_ss got=%0d/%h want=0/00", bus.mode, bus.ss_bcd);
    end
  endtask

  task automatic test_day_wrap();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 22; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rises(58);
    total++;
    if (dut_vec() !== {8'h23, 8'h59, 8'h58, 2'd0, 1'b1, 1'b0}) begin
      bad++; $display("FAIL preload_235958 got=%h", dut_vec());
    end
    rises(1);
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL at_235959 got=%h want=%h", dut_vec(), exp_vec());
    end
    rises(1);
    total++;
    if (dut_vec() !== {8'h00, 8'h00, 8'h00, 2'd0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL day_wrap got=%h want=%h", dut_vec(), {24'h0, 4'b0011});
    end
    step(1'b1, 1'b0, 1'b0, 1'b0);
    total++;
    if ({bus.tick, bus.day_wrap} !== 2'b00) begin
      bad++; $display("FAIL day_wrap_one_cycle got=%b%b want=00", bus.tick, bus.day_wrap);
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if ({bus.mode, bus.hh_bcd} !== {2'd2, 8'h00}) begin
      bad++; $display("FAIL mode_beats_inc got=%0d/%h want=2/00", bus.mode, bus.hh_bcd);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rises(59);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    total++;
    if (dut_vec() !== {8'h00, 8'h01, 8'h00, 2'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL rise_with_mode got=%h want=%h", dut_vec(), {24'h000100, 4'b0110});
    end
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (dut_vec() !== {8'h01, 8'h01, 8'h00, 2'd1, 1'b1, 1'b0}) begin
      bad++; $display("FAIL rise_with_inc_set got=%h want=%h", dut_vec(), exp_vec());
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 34; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    rises(56);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({bus.hh_bcd, bus.mm_bcd, bus.ss_bcd, bus.mode} !== {24'h123456, 2'd2}) begin
      bad++; $display("FAIL preload_123456 got=%h%h%h/%0d", bus.hh_bcd, bus.mm_bcd, bus.ss_bcd, bus.mode);
    end
    step(1'b1, 1'b0, 1'b0, 1'b1);
    total++;
    if (dut_vec() !== 28'h0) begin
      bad++; $display("FAIL reset_mid got=%h want=%h", dut_vec(), 28'h0);
    end
  endtask

  task automatic test_random();
    logic c1 = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 2) == 0) c1 = ~c1;
      step(c1, ($urandom_range(0, 19) == 0), ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 499) == 0));
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random i=%0d got=%h want=%h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0;
    m_prev = 1; m_tick = 0; m_wrap = 0;
    test_reset();
    test_tick();
    test_set();
    test_day_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
